// File: rtl/pipe_front_regs_if.sv
// pipe_front_regs_if: front-end pipeline register bus between the hazard/decode logic and the PC, IF/ID and ID/EX registers.
//   slave  : the register block (consumes stall/flush/redirect and D-side fields, drives F/D/E state and counters)
//   master : the surrounding pipeline / hazard unit
interface pipe_front_regs_if #(
    parameter int EX_W  = 128,
    parameter int CNT_W = 32
);
    logic             StallF;
    logic             StallD;
    logic             FlushE;
    logic             PCSrcD;
    logic [31:0]      PCBranchD;
    logic [31:0]      InstrF;
    logic [31:0]      PCF;
    logic [31:0]      InstrD;
    logic [31:0]      PCPlus4D;
    logic             ValidD;
    logic [4:0]       RsD;
    logic [4:0]       RtD;
    logic [4:0]       RdD;
    logic [EX_W-1:0]  PayloadD;
    logic [4:0]       RsE;
    logic [4:0]       RtE;
    logic [4:0]       RdE;
    logic [EX_W-1:0]  PayloadE;
    logic             ValidE;
    logic             CntClr;
    logic [CNT_W-1:0] StallCnt;
    logic [CNT_W-1:0] BubbleCnt;

    modport slave (
        input  StallF, StallD, FlushE, PCSrcD, PCBranchD, InstrF,
        input  RsD, RtD, RdD, PayloadD, CntClr,
        output PCF, InstrD, PCPlus4D, ValidD,
        output RsE, RtE, RdE, PayloadE, ValidE,
        output StallCnt, BubbleCnt
    );

    modport master (
        output StallF, StallD, FlushE, PCSrcD, PCBranchD, InstrF,
        output RsD, RtD, RdD, PayloadD, CntClr,
        input  PCF, InstrD, PCPlus4D, ValidD,
        input  RsE, RtE, RdE, PayloadE, ValidE,
        input  StallCnt, BubbleCnt
    );
endinterface

// File: rtl/pipe_front_regs.sv
// pipe_front_regs: PC, IF/ID and ID/EX registers of a 5-stage MIPS pipeline with valid bits and stall/bubble counters.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of pipe_front_regs_if
//           in  StallF/StallD/FlushE, PCSrcD/PCBranchD, InstrF, RsD/RtD/RdD/PayloadD, CntClr
//           out PCF, InstrD/PCPlus4D/ValidD, RsE/RtE/RdE/PayloadE/ValidE, StallCnt/BubbleCnt
// Every output comes straight from a flop.
module pipe_front_regs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          EX_W     = 128,
    parameter int          CNT_W    = 32
) (
    input logic               clk,
    input logic               rst_n,
    pipe_front_regs_if.slave  bus
);
    logic [31:0]      pcf_q, pcf_d;
    logic [31:0]      pc_plus4;
    logic [31:0]      instrd_q, instrd_d;
    logic [31:0]      pcp4d_q, pcp4d_d;
    logic             validd_q, validd_d;
    logic [4:0]       rse_q, rse_d;
    logic [4:0]       rte_q, rte_d;
    logic [4:0]       rde_q, rde_d;
    logic [EX_W-1:0]  payloade_q, payloade_d;
    logic             valide_q, valide_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic             stall_inc, bubble_inc;
    logic             squash_d;

    assign pc_plus4 = pcf_q + 32'd4;
    // A redirect only kills the D slot when IF/ID is actually loading this edge.
    assign squash_d   = bus.PCSrcD & ~bus.StallD;
    assign stall_inc  = bus.StallD;
    // A flush and a squash on the same edge count as a single bubble.
    assign bubble_inc = bus.FlushE | squash_d;

    always_comb begin
        pcf_d = bus.StallF ? pcf_q : (bus.PCSrcD ? bus.PCBranchD : pc_plus4);
    end

    always_comb begin
        instrd_d = bus.StallD ? instrd_q : (squash_d ? 32'd0 : bus.InstrF);
        pcp4d_d  = bus.StallD ? pcp4d_q  : (squash_d ? 32'd0 : pc_plus4);
        validd_d = bus.StallD ? validd_q : ~squash_d;
    end

    always_comb begin
        rse_d      = bus.FlushE ? 5'd0 : bus.RsD;
        rte_d      = bus.FlushE ? 5'd0 : bus.RtD;
        rde_d      = bus.FlushE ? 5'd0 : bus.RdD;
        payloade_d = bus.FlushE ? '0   : bus.PayloadD;
        valide_d   = bus.FlushE ? 1'b0 : validd_q;
    end

    always_comb begin
        stall_cnt_d  = bus.CntClr ? '0 :
                       (stall_inc && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        bubble_cnt_d = bus.CntClr ? '0 :
                       (bubble_inc && bubble_cnt_q != '1) ? bubble_cnt_q + 1'b1 : bubble_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcf_q        <= RESET_PC;
            instrd_q     <= '0;
            pcp4d_q      <= '0;
            validd_q     <= 1'b0;
            rse_q        <= '0;
            rte_q        <= '0;
            rde_q        <= '0;
            payloade_q   <= '0;
            valide_q     <= 1'b0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            pcf_q        <= pcf_d;
            instrd_q     <= instrd_d;
            pcp4d_q      <= pcp4d_d;
            validd_q     <= validd_d;
            rse_q        <= rse_d;
            rte_q        <= rte_d;
            rde_q        <= rde_d;
            payloade_q   <= payloade_d;
            valide_q     <= valide_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.PCF       = pcf_q;
    assign bus.InstrD    = instrd_q;
    assign bus.PCPlus4D  = pcp4d_q;
    assign bus.ValidD    = validd_q;
    assign bus.RsE       = rse_q;
    assign bus.RtE       = rte_q;
    assign bus.RdE       = rde_q;
    assign bus.PayloadE  = payloade_q;
    assign bus.ValidE    = valide_q;
    assign bus.StallCnt  = stall_cnt_q;
    assign bus.BubbleCnt = bubble_cnt_q;
endmodule

// File: tb/tb_pipe_front_regs.sv
// tb_pipe_front_regs: directed test of pipe_front_regs against a behavioural pipeline model plus literal checkpoints.
module tb_pipe_front_regs;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    pipe_front_regs_if #(.EX_W(128), .CNT_W(32)) bus ();
    pipe_front_regs_if #(.EX_W(128), .CNT_W(4))  bus2 ();

    pipe_front_regs #(.RESET_PC(32'h0), .EX_W(128), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    pipe_front_regs #(.RESET_PC(32'hFFFF_FFFC), .EX_W(128), .CNT_W(4)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    assign bus.InstrF  = imem(bus.PCF);
    assign bus2.InstrF = 32'd0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pipeline model: each stage is a record of what it holds; counters saturate on plain integers.
    logic [31:0]  m_pc, m_instrd, m_pcp4d;
    logic         m_vd, m_ve;
    logic [4:0]   m_rse, m_rte, m_rde;
    logic [127:0] m_paye;
    longint       m_sc, m_bc;
    localparam longint CMAX = 64'd4294967295;

    function automatic longint sat(input longint v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= 32'h0; m_instrd <= 0; m_pcp4d <= 0; m_vd <= 0;
            m_rse <= 0; m_rte <= 0; m_rde <= 0; m_paye <= 0; m_ve <= 0;
            m_sc <= 0; m_bc <= 0;
        end else begin
            if (bus.FlushE) begin
                m_rse <= 0; m_rte <= 0; m_rde <= 0; m_paye <= 0; m_ve <= 0;
            end else begin
                m_rse <= bus.RsD; m_rte <= bus.RtD; m_rde <= bus.RdD; m_paye <= bus.PayloadD; m_ve <= m_vd;
            end
            if (!bus.StallD) begin
                if (bus.PCSrcD) begin
                    m_instrd <= 0; m_pcp4d <= 0; m_vd <= 0;
                end else begin
                    m_instrd <= imem(m_pc); m_pcp4d <= m_pc + 32'd4; m_vd <= 1;
                end
            end
            if (!bus.StallF) m_pc <= bus.PCSrcD ? bus.PCBranchD : m_pc + 32'd4;
            m_sc <= bus.CntClr ? 0 : sat(m_sc + (bus.StallD ? 1 : 0));
            m_bc <= bus.CntClr ? 0 : sat(m_bc + ((bus.FlushE || (bus.PCSrcD && !bus.StallD)) ? 1 : 0));
        end
    end

    always @(negedge clk) begin
        check("PCF", bus.PCF, m_pc);
        check("InstrD", bus.InstrD, m_instrd);
        check("PCPlus4D", bus.PCPlus4D, m_pcp4d);
        check("ValidD", bus.ValidD, m_vd);
        check("RsE", bus.RsE, m_rse);
        check("RtE", bus.RtE, m_rte);
        check("RdE", bus.RdE, m_rde);
        check("PayloadE", bus.PayloadE, m_paye);
        check("ValidE", bus.ValidE, m_ve);
        check("StallCnt", bus.StallCnt, m_sc[31:0]);
        check("BubbleCnt", bus.BubbleCnt, m_bc[31:0]);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ctl(input logic sf, input logic sd, input logic fe, input logic ps, input logic [31:0] tgt);
        bus.StallF = sf; bus.StallD = sd; bus.FlushE = fe; bus.PCSrcD = ps; bus.PCBranchD = tgt;
    endtask

    initial begin
        rst_n = 1'b0;
        ctl(0, 0, 0, 0, 32'h0);
        bus.CntClr = 0;
        bus.RsD = 5'd3; bus.RtD = 5'd7; bus.RdD = 5'd9;
        bus.PayloadD = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        bus2.StallF = 1; bus2.StallD = 1; bus2.FlushE = 0; bus2.PCSrcD = 0; bus2.PCBranchD = 0;
        bus2.CntClr = 0; bus2.RsD = 0; bus2.RtD = 0; bus2.RdD = 0; bus2.PayloadD = '0;
        repeat (2) tick();
        check("rst PCF", bus.PCF, 32'h0);
        check("rst ValidD", bus.ValidD, 1'b0);
        check("rst ValidE", bus.ValidE, 1'b0);
        rst_n = 1'b1;
        // straight-line fetch
        tick();
        check("t1 PCF", bus.PCF, 32'h4);
        check("t1 InstrD", bus.InstrD, imem(32'h0));
        check("t1 PCPlus4D", bus.PCPlus4D, 32'h4);
        check("t1 ValidD", bus.ValidD, 1'b1);
        check("t1 ValidE", bus.ValidE, 1'b0);
        tick();
        check("t1 PCF8", bus.PCF, 32'h8);
        check("t1 ValidE2", bus.ValidE, 1'b1);
        check("t1 RsE", bus.RsE, 5'd3);
        check("t1 PayloadE", bus.PayloadE, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        tick();
        check("t1 PCFC", bus.PCF, 32'hC);
        tick();
        check("t1 PCF10", bus.PCF, 32'h10);
        check("t1 InstrD C", bus.InstrD, imem(32'hC));
        // load-use stall
        ctl(1, 1, 1, 0, 32'h0);
        tick();
        check("t2 PCF", bus.PCF, 32'h10);
        check("t2 InstrD", bus.InstrD, imem(32'hC));
        check("t2 PCPlus4D", bus.PCPlus4D, 32'h10);
        check("t2 ValidE", bus.ValidE, 1'b0);
        check("t2 PayloadE", bus.PayloadE, 128'h0);
        check("t2 RsE", bus.RsE, 5'd0);
        check("t2 RtE", bus.RtE, 5'd0);
        check("t2 StallCnt", bus.StallCnt, 32'd1);
        check("t2 BubbleCnt", bus.BubbleCnt, 32'd1);
        ctl(0, 0, 0, 0, 32'h0);
        tick();
        check("t2 PCF14", bus.PCF, 32'h14);
        check("t2 ValidE resume", bus.ValidE, 1'b1);
        // taken branch
        ctl(0, 0, 0, 1, 32'h40);
        tick();
        check("t3 PCF", bus.PCF, 32'h40);
        check("t3 InstrD", bus.InstrD, 32'h0);
        check("t3 PCPlus4D", bus.PCPlus4D, 32'h0);
        check("t3 ValidD", bus.ValidD, 1'b0);
        check("t3 BubbleCnt", bus.BubbleCnt, 32'd2);
        ctl(0, 0, 0, 0, 32'h0);
        tick();
        check("t3 PCF44", bus.PCF, 32'h44);
        check("t3 ValidE", bus.ValidE, 1'b0);
        tick();
        check("t3 PCF48", bus.PCF, 32'h48);
        check("t3 InstrD44", bus.InstrD, imem(32'h44));
        check("t3 ValidE1", bus.ValidE, 1'b1);
        // branch under stall, then branch plus flush
        ctl(1, 1, 0, 1, 32'h100);
        tick();
        check("t4 PCF", bus.PCF, 32'h48);
        check("t4 InstrD", bus.InstrD, imem(32'h44));
        check("t4 PCPlus4D", bus.PCPlus4D, 32'h48);
        check("t4 ValidD", bus.ValidD, 1'b1);
        check("t4 BubbleCnt", bus.BubbleCnt, 32'd2);
        check("t4 StallCnt", bus.StallCnt, 32'd2);
        ctl(0, 0, 1, 1, 32'h78);
        tick();
        check("t4 BubbleCnt once", bus.BubbleCnt, 32'd3);
        check("t4 PCF78", bus.PCF, 32'h78);
        check("t4 ValidD0", bus.ValidD, 1'b0);
        ctl(0, 0, 0, 0, 32'h0);
        tick();
        tick();
        check("t5 PCF80", bus.PCF, 32'h80);
        check("t5 ValidE pre", bus.ValidE, 1'b1);
        // asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        check("t5 PCF", bus.PCF, 32'h0);
        check("t5 ValidD", bus.ValidD, 1'b0);
        check("t5 ValidE", bus.ValidE, 1'b0);
        check("t5 InstrD", bus.InstrD, 32'h0);
        check("t5 PayloadE", bus.PayloadE, 128'h0);
        check("t5 StallCnt", bus.StallCnt, 32'd0);
        check("t5 BubbleCnt", bus.BubbleCnt, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t5 restart PCF", bus.PCF, 32'h4);
        check("t5 restart ValidD", bus.ValidD, 1'b1);
        // narrow counter saturation and PC wrap on the second instance
        check("t6 PCF reset", bus2.PCF, 32'hFFFF_FFFC);
        bus2.StallF = 0; bus2.CntClr = 1;
        tick();
        check("t6 PCF wrap", bus2.PCF, 32'h0);
        check("t6 clr", bus2.StallCnt, 4'd0);
        bus2.StallF = 1; bus2.CntClr = 0;
        repeat (14) tick();
        check("t6 cnt14", bus2.StallCnt, 4'd14);
        repeat (6) tick();
        check("t6 sat", bus2.StallCnt, 4'd15);
        bus2.CntClr = 1;
        tick();
        check("t6 clr prio", bus2.StallCnt, 4'd0);
        bus2.CntClr = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_front_regs.md
Name: pipe_front_regs

Overview:
- Consumes the hazard unit's StallF/StallD/FlushE and the decode-stage branch redirect (PCSrcD/PCBranchD).
- Holds the PC register, the IF/ID register and the ID/EX register of the 5-stage MIPS pipeline, plus per-stage valid bits.
- Feeds RsE/RtE back to the hazard unit.
- Keeps saturating stall and bubble counters for performance measurement.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- EX_W, 128, width of the packed ID/EX payload (control, RD1, RD2, SignImm).
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- StallF  in  1  hold PC
- StallD  in  1  hold IF/ID
- FlushE  in  1  insert bubble into ID/EX
- PCSrcD  in  1  taken branch/jump resolved in D
- PCBranchD  in  32  redirect target
- InstrF  in  32  instruction read at PCF (combinational imem)
- PCF  out  32  fetch PC
- InstrD  out  32  decode instruction
- PCPlus4D  out  32  PC+4 of InstrD
- ValidD  out  1  InstrD is a real instruction
- RsD, RtD, RdD  in  5 each  register fields from decode
- PayloadD  in  EX_W  decoded control/operands
- RsE, RtE, RdE  out  5 each  registered fields
- PayloadE  out  EX_W  registered payload
- ValidE  out  1  E-stage instruction is real
- CntClr  in  1  synchronous counter clear
- StallCnt  out  CNT_W  cycles with StallD=1
- BubbleCnt  out  CNT_W  bubbles inserted

Behaviour:
Reset (rst_n=0, asynchronous, effective immediately, including mid-operation):
- PCF=RESET_PC.
- InstrD=0, PCPlus4D=0, ValidD=0.
- RsE/RtE/RdE=0, PayloadE=0, ValidE=0.
- StallCnt=0, BubbleCnt=0.

PC register (updates on each rising edge):
- StallF=1: hold.
- Otherwise: PCF <= PCSrcD ? PCBranchD : PCF+4.
- StallF has priority over PCSrcD.
- PCF+4 wraps modulo 2^32.

IF/ID register:
- StallD=1: hold all D outputs. StallD has priority over PCSrcD.
- StallD=0 and PCSrcD=1: squash. InstrD=0 (nop sll $0), PCPlus4D=0, ValidD=0.
- Otherwise: InstrD<=InstrF, PCPlus4D<=PCF+4, ValidD<=1.

ID/EX register (never stalls):
- FlushE=1: RsE/RtE/RdE/PayloadE<=0, ValidE<=0.
- Otherwise: capture RsD/RtD/RdD/PayloadD, and ValidE<=ValidD.
- The ID/EX register does not inspect the D-side inputs; an invalid D instruction propagates with ValidE=0.

Latency:
- InstrF to InstrD: 1 cycle.
- InstrD to E: 1 cycle.
- Redirect is visible on PCF the edge after PCSrcD=1.

Independence of control inputs:
- StallF, StallD and FlushE are handled independently; no combination is illegal.
- The hazard unit normally asserts all three together.

Counters:
- StallCnt +1 each edge with StallD=1.
- BubbleCnt +1 each edge with FlushE=1, and +1 (not +2) each edge with PCSrcD=1 && StallD=0; if both conditions hold on the same edge, it increments once.
- Both counters saturate at 2^CNT_W-1.
- CntClr=1 zeroes both counters on the edge and has priority over increment.

No combinational paths from inputs to outputs.

Test Plan:
1. Reset release, InstrF=PCF-dependent pattern, no stalls -> PCF 0,4,8,C on successive edges; ValidD=1 after edge 1; ValidE=1 after edge 2; InstrD equals word fetched at previous PCF.
2. Load-use: at PCF=0x10, StallF=StallD=FlushE=1 for one cycle -> PCF stays 0x10, InstrD/PCPlus4D unchanged, next-cycle ValidE=0 and PayloadE=0, RsE=RtE=0; StallCnt=1, BubbleCnt=1; resumes 0x14 next edge.
3. Taken branch: PCSrcD=1, PCBranchD=0x40, no stalls -> PCF=0x40, InstrD=0, ValidD=0, ValidE=0 one cycle later; BubbleCnt increments by 1.
4. Branch with stall: PCSrcD=1, StallF=StallD=1 -> PCF and all D outputs unchanged, BubbleCnt unchanged; with PCSrcD=1, StallD=0 and FlushE=1 -> BubbleCnt increments by exactly 1.
5. Async reset mid-run: drop rst_n between edges at PCF=0x80 with ValidE=1 -> all outputs reset without a clock edge; release -> sequence restarts at RESET_PC.
6. CNT_W=4, StallD=1 for 20 cycles -> StallCnt=15 (saturated); CntClr=1 with StallD=1 -> StallCnt=0. Separately, RESET_PC=32'hFFFF_FFFC -> PCF wraps to 0 after one edge.
